// File: rtl/calc_key_sequencer.sv
// Pushbutton front end for the calculator. It debounces three active-low keys and turns
// each clean press into one op/A/B command, handed downstream with a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a single clean key press
// PEND  | command presented on op/A/B, valid high until ready
// HOLD  | command transferred, waiting for all keys to be released
module calc_key_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [2:0] KEY,
    input  logic [7:0] SW,
    input  logic       ready,
    output logic       valid,
    output logic [2:0] op,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       sync1, sync2;
    logic [2:0]       db_lvl, db_prev;
    logic [CNT_W-1:0] cnt [3];
    logic [2:0]       press, held;
    logic             press_multi, other_held;
    logic             capture, err_nxt;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // The level flips on the edge where the disagreement count reaches its limit.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            db_lvl  <= 3'b111;
            db_prev <= 3'b111;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            db_prev <= db_lvl;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]    <= '0;
                    db_lvl[i] <= sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press       = db_prev & ~db_lvl;
    assign held        = ~db_lvl;
    assign press_multi = (press & (press - 3'd1)) != 3'b000;
    assign other_held  = (held & ~press) != 3'b000;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (press != 3'b000) begin
                    if (!press_multi && !other_held) begin
                        capture   = 1'b1;
                        state_nxt = PEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            PEND: begin
                err_nxt = |press;
                if (ready) state_nxt = HOLD;
            end
            HOLD: begin
                err_nxt = |press;
                if (&db_lvl) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            op  <= 3'b000;
            A   <= 4'h0;
            B   <= 4'h0;
            err <= 1'b0;
        end else begin
            err <= err_nxt;
            if (capture) begin
                op <= press;
                A  <= SW[7:4];
                B  <= SW[3:0];
            end
        end
    end

    assign valid = (state == PEND);
    assign busy  = (state != IDLE);

endmodule
